// File: rtl/ccff_pkg.sv
// Shared types for the configuration-chain loader.
// State encoding and a small sizing helper.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int unsigned ceil_div(
    input int unsigned a,
    input int unsigned b
  );
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Word-wide parallel-in serial-out register, MSB first,
// with a count of bits still to be shifted out.
module ccff_piso #(
  parameter int WORD_W = 8,
  parameter int SC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [SC_W-1:0]   load_cnt,
  output logic              msb,
  output logic              shift_en
);

  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [SC_W-1:0]   cnt_q, cnt_d;

  assign shift_en = (cnt_q != '0);
  assign msb      = sreg_q[WORD_W-1];

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      sreg_d = load_data;
      cnt_d  = load_cnt;
    end else if (shift_en) begin
      sreg_d = sreg_q << 1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serialises bitstream words onto
// one scan chain and optionally compares the returning tail bits.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int SC_W = $clog2(WORD_W + 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  logic             sreg_clr;
  logic             sreg_load;
  logic [SC_W-1:0]  load_cnt;
  int               rem;

  ccff_piso #(
    .WORD_W (WORD_W),
    .SC_W   (SC_W)
  ) u_piso (
    .clk       (prog_clk),
    .rst_n     (pReset_n),
    .clr       (sreg_clr),
    .load      (sreg_load),
    .load_data (word_in),
    .load_cnt  (load_cnt),
    .msb       (ccff_head),
    .shift_en  (ccff_shift_en)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;
  assign mismatch_cnt = mcnt_q;

  // Surplus bits of the last word are never counted in.
  always_comb begin
    rem      = CHAIN_LEN - int'(bit_cnt_q);
    load_cnt = (rem > WORD_W) ? SC_W'(WORD_W) : SC_W'(rem);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    error_d    = error_q;
    mcnt_d     = mcnt_q;
    sreg_clr   = 1'b0;
    sreg_load  = 1'b0;
    word_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = verify;
          bit_cnt_d = '0;
          error_d   = 1'b0;
          mcnt_d    = '0;
          sreg_clr  = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        word_ready = !ccff_shift_en
                  && (bit_cnt_q < CNT_W'(CHAIN_LEN));
        sreg_load  = word_valid && word_ready;
        if (ccff_shift_en) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Tail carries the same bit index of the previous pass.
          if (mode_q && (ccff_tail != ccff_head)) begin
            error_d = 1'b1;
            if (mcnt_q != '1) mcnt_d = mcnt_q + 1'b1;
          end
        end
        if (bit_cnt_q == CNT_W'(CHAIN_LEN)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      bit_cnt_q <= '0;
      error_q   <= 1'b0;
      mcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bit_cnt_q <= bit_cnt_d;
      error_q   <= error_d;
      mcnt_q    <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: chain model plus stream-level
// reference for a 10-bit chain, and a 16-bit exact-multiple case.
module tb_ccff_loader;

  localparam int CL  = 10;
  localparam int CLB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(
    input string n,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               n, got, exp, $time);
    end
  endfunction

  // DUT A: 10-flop chain
  logic       start_a = 0, verify_a = 0, wvalid_a = 0;
  logic [7:0] word_a = 0;
  logic       wready_a, head_a, sen_a, tail_a;
  logic       busy_a, done_a, err_a;
  logic [3:0] mcnt_a;

  ccff_loader #(.CHAIN_LEN(CL), .WORD_W(8)) u_a (
    .prog_clk      (clk),
    .pReset_n      (rst_n),
    .start         (start_a),
    .verify        (verify_a),
    .word_in       (word_a),
    .word_valid    (wvalid_a),
    .word_ready    (wready_a),
    .ccff_head     (head_a),
    .ccff_shift_en (sen_a),
    .ccff_tail     (tail_a),
    .busy          (busy_a),
    .done          (done_a),
    .error         (err_a),
    .mismatch_cnt  (mcnt_a)
  );

  // DUT B: 16-flop chain, load only
  logic       start_b = 0, wvalid_b = 0;
  logic [7:0] word_b = 0;
  logic       wready_b, head_b, sen_b;
  logic       busy_b, done_b, err_b;
  logic [4:0] mcnt_b;

  ccff_loader #(.CHAIN_LEN(CLB), .WORD_W(8)) u_b (
    .prog_clk      (clk),
    .pReset_n      (rst_n),
    .start         (start_b),
    .verify        (1'b0),
    .word_in       (word_b),
    .word_valid    (wvalid_b),
    .word_ready    (wready_b),
    .ccff_head     (head_b),
    .ccff_shift_en (sen_b),
    .ccff_tail     (1'b0),
    .busy          (busy_b),
    .done          (done_b),
    .error         (err_b),
    .mismatch_cnt  (mcnt_b)
  );

  // Chain model: chain[0] at head, chain[CL-1] drives tail.
  logic [CL-1:0] chain = '0;
  assign tail_a = chain[CL-1];
  always @(posedge clk)
    if (sen_a) chain <= {chain[CL-2:0], head_a};

  // Observation monitors
  logic [15:0] hseq = 0, hb = 0;
  int nsen = 0, dcnt = 0, nb = 0, db = 0;
  always @(negedge clk) begin
    if (sen_a) begin
      hseq <= {hseq[14:0], head_a};
      nsen <= nsen + 1;
    end
    if (done_a) dcnt <= dcnt + 1;
    if (sen_b) begin
      hb <= {hb[14:0], head_b};
      nb <= nb + 1;
    end
    if (done_b) db <= db + 1;
  end

  // Stream-level reference for DUT A
  logic [15:0] sbits = 0;
  bit in_pass = 0, mode = 0, exp_err = 0;
  int nshift = 0, post = 0, pending = 0, exp_mis = 0;
  logic exp_ready, exp_sen, exp_done, exp_bit;

  assign exp_ready = in_pass && (nshift < CL) && (pending == 0);
  assign exp_sen   = in_pass && (pending > 0);
  assign exp_done  = in_pass && (nshift == CL) && (post == 1);
  assign exp_bit   = sbits[4'(15 - nshift)];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pass <= 0; nshift <= 0; post <= 0;
      pending <= 0; exp_err <= 0; exp_mis <= 0;
    end else if (!in_pass) begin
      if (start_a) begin
        in_pass <= 1; mode <= verify_a;
        nshift  <= 0; post <= 0; pending <= 0;
        exp_err <= 0; exp_mis <= 0;
      end
    end else if (nshift == CL) begin
      post <= post + 1;
      if (post == 1) in_pass <= 0;
    end else if (pending > 0) begin
      if (mode && (chain[CL-1] != exp_bit)) begin
        exp_err <= 1;
        exp_mis <= (exp_mis < 15) ? exp_mis + 1 : 15;
      end
      nshift  <= nshift + 1;
      pending <= pending - 1;
    end else if (wvalid_a) begin
      pending <= (CL - nshift > 8) ? 8 : CL - nshift;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",     busy_a,   exp_busy());
      chk("done",     done_a,   exp_done);
      chk("ready",    wready_a, exp_ready);
      chk("shift_en", sen_a,    exp_sen);
      chk("error",    err_a,    exp_err);
      chk("mis_cnt",  mcnt_a,   exp_mis);
      if (exp_sen) chk("head", head_a, exp_bit);
    end
  end

  function automatic logic exp_busy();
    return in_pass;
  endfunction

  int cs, lat, err_at_start;

  task automatic start_pass(input bit v, input logic [7:0] w0, w1);
    sbits    = {w0, w1};
    start_a  = 1;
    verify_a = v;
    @(posedge clk); #1;
    cs = cyc;
    err_at_start = int'(err_a);
    start_a = 0;
  endtask

  task automatic feed(input logic [7:0] w, input int gap);
    int t = 0;
    bit acc = 0;
    while (!acc && t < 200) begin
      word_a   = w;
      wvalid_a = ($urandom_range(0, 99) >= gap);
      @(negedge clk);
      acc = wvalid_a && wready_a;
      @(posedge clk); #1;
      t++;
    end
    wvalid_a = 0;
    chk("feed_a", acc, 1);
  endtask

  task automatic do_stall();
    int t = 0;
    @(negedge clk);
    while (!wready_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_sen", sen_a, 0);
      chk("stall_rdy", wready_a, 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_a && t < 100);
    chk("done_seen", done_a, 1);
    lat = cyc - cs + 1;
    @(posedge clk); #1;
  endtask

  task automatic run_pass(
    input bit v, input logic [7:0] w0, w1,
    input int gap, input bit stall, input bit poke
  );
    start_pass(v, w0, w1);
    feed(w0, gap);
    if (poke) begin
      start_a = 1;
      @(posedge clk); #1;
      start_a = 0;
    end
    if (stall) do_stall();
    feed(w1, gap);
    wait_done();
  endtask

  task automatic feed_b(input logic [7:0] w);
    int t = 0;
    bit acc = 0;
    word_b   = w;
    wvalid_b = 1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = wready_b;
      @(posedge clk); #1;
      t++;
    end
    wvalid_b = 0;
    chk("feed_b", acc, 1);
  endtask

  initial begin
    int n0, d0, k, t;
    int nb0, db0, csb, latb;
    #1 rst_n = 0;
    #2;
    chk("rst_ready", wready_a, 0);
    chk("rst_head",  head_a,   0);
    chk("rst_sen",   sen_a,    0);
    chk("rst_busy",  busy_a,   0);
    chk("rst_done",  done_a,   0);
    chk("rst_err",   err_a,    0);
    chk("rst_mcnt",  mcnt_a,   0);
    chk("rst_busy_b", busy_b,  0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Basic load
    n0 = nsen;
    run_pass(0, 8'hA5, 8'hC0, 0, 0, 0);
    chk("basic_nsen",  nsen - n0, 10);
    chk("basic_head",  hseq[9:0], 10'b1010010111);
    chk("basic_chain", chain,     10'b1010010111);
    chk("basic_lat",   lat,       14);

    // Verify pass, identical data
    run_pass(1, 8'hA5, 8'hC0, 0, 0, 0);
    chk("vok_err",   err_a,  0);
    chk("vok_mcnt",  mcnt_a, 0);
    chk("vok_chain", chain,  10'b1010010111);

    // Verify mismatch on bit 7
    run_pass(1, 8'hA4, 8'hC0, 0, 0, 0);
    chk("vbad_err",  err_a,  1);
    chk("vbad_mcnt", mcnt_a, 1);

    // Stall between words; error clears on start
    n0 = nsen;
    run_pass(0, 8'hA5, 8'hC0, 0, 1, 0);
    chk("err_clear",  err_at_start, 0);
    chk("stall_nsen", nsen - n0, 10);
    chk("stall_head", hseq[9:0], 10'b1010010111);
    chk("stall_lat",  lat, 19);

    // Reset after 4 shifts
    d0 = dcnt;
    start_pass(0, 8'h5A, 8'h3C);
    feed(8'h5A, 0);
    k = 0; t = 0;
    while (k < 4 && t < 30) begin
      @(negedge clk);
      if (sen_a) k++;
      t++;
    end
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("abort_sen",   sen_a,    0);
    chk("abort_ready", wready_a, 0);
    chk("abort_busy",  busy_a,   0);
    chk("abort_head",  head_a,   0);
    chk("abort_done",  done_a,   0);
    chk("abort_mcnt",  mcnt_a,   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    chk("abort_nodone", dcnt - d0, 0);

    // Full pass after reset, with start poked mid-pass
    n0 = nsen;
    run_pass(0, 8'h5A, 8'h3C, 0, 0, 1);
    chk("post_nsen", nsen - n0, 10);
    chk("post_head", hseq[9:0], 10'b0101101000);
    chk("post_lat",  lat, 14);

    // Randomized passes against the reference
    for (int i = 0; i < 40; i++) begin
      run_pass($urandom_range(0, 1),
               8'($urandom), 8'($urandom),
               $urandom_range(0, 60), 0,
               ($urandom_range(0, 3) == 0));
    end

    // Exact-multiple chain on DUT B
    nb0 = nb; db0 = db;
    start_b = 1;
    @(posedge clk); #1;
    csb = cyc;
    start_b = 0;
    feed_b(8'h3C);
    feed_b(8'hE1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done_b && t < 100);
    chk("b_done_seen", done_b, 1);
    latb = cyc - csb + 1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_lat",   latb,     20);
    chk("b_nsen",  nb - nb0, 16);
    chk("b_head",  hb,       16'h3CE1);
    chk("b_ndone", db - db0, 1);
    chk("b_busy",  busy_b,   0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ccff_loader.md
# ccff_loader

Configuration-chain loader for the FPGA fabric's scan-chain memories.
- Accepts bitstream words from the host side over a valid/ready handshake and serialises them MSB-first onto `ccff_head`.
- Qualifies each chain shift with `ccff_shift_en` (gates the chain's shift clock).
- In verify mode, checks the bits returning on `ccff_tail` against a second pass of the same bitstream.
- Sits at the head/tail of one configuration chain, e.g. a connection block's mux memories.

## Interface

Parameters:
- `CHAIN_LEN`, default 10: number of flops in the attached chain; must be ≥1.
- `WORD_W`, default 8: bitstream word width; must be ≥1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: bit-counter width.

Ports:
- `prog_clk` input, 1 bit: programming clock. This is the only clock.
- `pReset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a pass. Sampled only in IDLE.
- `verify` input, 1 bit: mode for the pass, sampled with `start`. 0 = load, 1 = load and compare.
- `word_in` input, `WORD_W` bits: bitstream word, MSB shifted first.
- `word_valid` input, 1 bit: `word_in` is valid.
- `word_ready` output, 1 bit: loader accepts `word_in` this cycle.
- `ccff_head` output, 1 bit: serial data to the chain head.
- `ccff_shift_en` output, 1 bit: the chain shifts on this `prog_clk` edge.
- `ccff_tail` input, 1 bit: serial data returning from the chain tail.
- `busy` output, 1 bit: a pass is in progress.
- `done` output, 1 bit: one-cycle pulse when a pass completes.
- `error` output, 1 bit: sticky verify mismatch flag; cleared by the next accepted `start`.
- `mismatch_cnt` output, `CNT_W` bits: count of verify mismatches, saturating.

## Operation

States are IDLE, SHIFT, DONE.

IDLE
- `start`=1 latches `verify` into `mode`.
- Clears `bit_cnt`, `sreg_cnt`, `error` and `mismatch_cnt`.
- Moves to SHIFT.

SHIFT
- Word load:
  - `word_ready` = (`sreg_cnt`==0) && (`bit_cnt` < `CHAIN_LEN`).
  - On `word_valid` && `word_ready`: `sreg` ← `word_in`, and `sreg_cnt` ← min(`WORD_W`, `CHAIN_LEN` − `bit_cnt`).
- Shifting:
  - `ccff_shift_en` = (`sreg_cnt` ≠ 0). Both outputs are combinational from registers.
  - `ccff_head` = `sreg[WORD_W-1]`.
  - On each edge with `ccff_shift_en`=1: `sreg` shifts left by 1, `sreg_cnt`−1, `bit_cnt`+1.
- Surplus bits in the final word beyond `CHAIN_LEN` are never shifted; they are discarded.
- Verify (`mode`=1):
  - On every shifting edge, compare `ccff_tail` with `ccff_head`.
  - The chain is exactly `CHAIN_LEN` deep, so the tail carries bit k of the previous pass while the head carries bit k of this pass.
  - On a mismatch: `error` ← 1 and `mismatch_cnt` +1, saturating at all-ones.
- When `bit_cnt` reaches `CHAIN_LEN`, move to DONE.

DONE
- `done`=1 for exactly one cycle, then IDLE.

Other rules:
- A word stall (`word_valid`=0 with an empty `sreg`) holds `ccff_shift_en`=0; the chain is untouched.
- `start` outside IDLE is ignored.
- `word_valid` outside SHIFT is not accepted; `word_ready`=0.
- `busy` = (state ≠ IDLE).
- The chain therefore receives exactly `CHAIN_LEN` shift pulses per pass.

## Timing

- Reset values: state IDLE, `word_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `error`=0, `mismatch_cnt`=0.
- `pReset_n` asserted mid-pass aborts immediately. `ccff_shift_en` drops asynchronously, so the chain holds partial contents. No `done` is issued.
- `start` at edge E: `busy`=1 and `word_ready`=1 after E.
- Word accepted at edge W: its bits shift on edges W+1 … W+n.
- `word_ready` reasserts in the cycle after the last bit shifts, giving one bubble cycle per word.
- Minimum pass time with no stalls: `CHAIN_LEN` + ceil(`CHAIN_LEN`/`WORD_W`) + 2 cycles from `start` to `done`.
- `error` and `mismatch_cnt` are final when `done` is high and hold until the next accepted `start`.

## Structure

- Shared package `ccff_pkg`: state encoding (IDLE/SHIFT/DONE) and a ceil-divide function for the word count.
- One sub-module, `ccff_piso`: `WORD_W` shift register with load, shift enable and bit count.
- The FSM, `bit_cnt` and verify logic live in `ccff_loader`.

## Test plan

All scenarios use a behavioural chain model (`CHAIN_LEN` flops clocked when `ccff_shift_en`=1) unless stated otherwise.

- **Basic load.** `CHAIN_LEN`=10, `WORD_W`=8, load mode, words 0xA5 then 0xC0.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1,1,1.
  - Exactly 10 `ccff_shift_en` pulses, then `done` for 1 cycle.
  - Chain model holds 1010010111 (head-first order).
- **Verify pass.** After the basic load, run verify mode with 0xA5, 0xC0 again.
  - `error`=0 and `mismatch_cnt`=0 at `done`; chain contents unchanged.
- **Verify mismatch.** Verify mode with 0xA4, 0xC0 after the basic load.
  - `error`=1 and `mismatch_cnt`=1. `error` clears on the next `start`.
- **Stall.** Hold `word_valid` low for 5 cycles between the two words.
  - `ccff_shift_en`=0 and `word_ready`=1 throughout the stall.
  - Total shifts still 10; head sequence as in basic load.
- **Reset and ignored start.** Assert `pReset_n`=0 after 4 shifts.
  - All outputs return to reset values; no `done`.
  - After reset release, a full pass completes normally.
  - `start` pulsed during SHIFT has no effect.
- **Exact-multiple chain.** `CHAIN_LEN`=16, `WORD_W`=8.
  - Two words give 16 shifts; no surplus discard.
  - `done` arrives at cycle 20 after `start`.
